inv_factorial: RTL and testbench
================================

INV_FACTORIAL -- requirements
Module: inv_factorial

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, the single clock. All state changes on the rising edge.
REQ-003 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, request to begin an inverse-factorial search. Sampled only in IDLE.
REQ-005 Port `Data_i`: input, 8 bits, unsigned candidate factorial value. Sampled on the edge where `start` is accepted.
REQ-006 Port `Out`: output, 8 bits, the n for which n! == `Data_i`, or 0 if no such n exists.
REQ-007 Port `exact`: output, 1 bit, set to 1 when `Data_i` is an exact factorial.
REQ-008 Port `done`: output, 1 bit, single-cycle completion pulse.

Function
REQ-009 The FSM SHALL have exactly five states: IDLE, LOAD, DIV, CHECK, DONE.
REQ-010 In IDLE with `start`=1: capture `Data_i` into `val`; next state is LOAD. In IDLE with `start`=0: stay in IDLE.
REQ-011 `start` SHALL be ignored in every state other than IDLE; no queuing.
REQ-012 LOAD behaviour depends on `val`:
- `val`=0: set `Out`=0 and `exact`=0; go to DONE.
- `val`=1: set `Out`=1 and `exact`=1; go to DONE.
- Otherwise: set `rem`=`val`, `quot`=0, `k`=2; go to DIV.
REQ-013 DIV SHALL perform one restoring-subtraction step per cycle:
- If `rem` >= `k`: `rem` <= `rem`-`k`, `quot` <= `quot`+1; stay in DIV.
- Otherwise: go to CHECK.
REQ-014 CHECK behaviour:
- `rem` != 0: set `Out`=0 and `exact`=0; go to DONE.
- `rem`=0 and `quot`=1: set `Out`=`k` and `exact`=1; go to DONE.
- Otherwise: `rem` <= `quot`, `quot` <= 0, `k` <= `k`+1; go to DIV.
REQ-015 DONE SHALL assert `done`=1 for exactly one cycle, then go unconditionally to IDLE.
REQ-016 `Out` and `exact` SHALL hold their values from DONE until the next LOAD or CHECK update of a new search. They SHALL NOT change in IDLE.
REQ-017 Width rules:
- `rem`, `quot` and `k` are 8 bits, unsigned.
- The largest reachable `k` is 6, since 5!=120 and 6!=720 exceeds 8 bits.
- No overflow is possible and no saturation logic is required.
REQ-018 Latency for `Data_i`=2 SHALL be 5 edges from the start-accepting edge to the edge entering DONE: LOAD, DIV, DIV, CHECK, DONE. In general, latency equals 2 + the sum over k of (quot_k + 2).
REQ-019 `start` held high through DONE SHALL launch a new search on the first IDLE cycle after DONE.

Reset
REQ-020 On `rst`=1, asynchronously and regardless of state, the block SHALL:
- force the state to IDLE;
- drive `Out`=0, `exact`=0, `done`=0;
- clear `val`, `rem` and `quot` to 0, and set `k`=2.
REQ-021 Reset asserted mid-search SHALL abort the search with no `done` pulse.
REQ-022 After `rst` deasserts, the first `start` SHALL be accepted on the first subsequent rising edge.

Structure
REQ-023 A shared package `inv_fact_pkg` SHALL hold:
- the state enum (IDLE, LOAD, DIV, CHECK, DONE);
- `DATA_W`=8;
- `K_INIT`=2.
REQ-024 The block SHALL split into the FSM (`inv_factorial`) and one sub-module `inv_fact_datapath`.
- `inv_fact_datapath` owns the `val`/`rem`/`quot`/`k` registers, the subtractor and the comparators.
- It exports `ge`=(`rem`>=`k`), `rem_zero` and `quot_one` to the FSM.
- This mirrors the team's existing controller/datapath split.
REQ-025 The target implementation size is 120-400 lines of RTL in total.

Verification
REQ-026 `Data_i`=120 with `start` -> `done` pulse, `Out`=5, `exact`=1.
REQ-027 `Data_i`=24 -> `Out`=4, `exact`=1. `Data_i`=2 -> `Out`=2, `exact`=1, `done` on the 5th edge after start acceptance.
REQ-028 Boundary values:
- `Data_i`=1 -> `Out`=1, `exact`=1, `done` 2 edges after acceptance.
- `Data_i`=0 -> `Out`=0, `exact`=0.
REQ-029 Non-factorial values:
- `Data_i`=7 -> `Out`=0, `exact`=0 (7/2 leaves remainder 1).
- `Data_i`=12 -> `Out`=0, `exact`=0 (12/2=6, 6/3=2, 2/4 leaves remainder 2).
REQ-030 Search `Data_i`=120; assert `rst` 10 edges into DIV -> no `done`, `Out`=0, state IDLE. Then search `Data_i`=6 -> `Out`=3, `exact`=1.
REQ-031 Pulse `start` with `Data_i`=0 while busy on 120 -> ignored, result stays `Out`=5. Then hold `start` high with `Data_i`=6 -> back-to-back result `Out`=3 immediately after.

Source files
------------

// File: rtl/inv_fact_pkg.sv
// Shared definitions for the inverse-factorial search block.
//   DATA_W  : width of the candidate value and of every datapath register
//   K_INIT  : first divisor tried (n! is divided by 2, 3, 4, ... in turn)
//   state_t : controller states
package inv_fact_pkg;
  localparam int          DATA_W = 8;
  localparam logic [7:0]  K_INIT = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    CHECK,
    DONE
  } state_t;
endpackage

// File: rtl/inv_fact_datapath.sv
// Datapath for the inverse-factorial search: holds the captured value and the
// running division registers, performs one restoring subtraction per cycle.
//   clk, rst           : clock, async active-high reset
//   ld_val, data_i     : capture candidate value into val
//   init               : start division of val by K_INIT
//   sub                : rem -= k, quot += 1
//   next_k             : quotient becomes the new dividend, k += 1
//   val, k             : registered value / current divisor
//   ge, rem_zero, quot_one : status flags for the controller
module inv_fact_datapath
  import inv_fact_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_val,
  input  logic              init,
  input  logic              sub,
  input  logic              next_k,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] k,
  output logic              ge,
  output logic              rem_zero,
  output logic              quot_one
);
  logic [DATA_W-1:0] rem, quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val  <= '0;
      rem  <= '0;
      quot <= '0;
      k    <= K_INIT;
    end else begin
      if (ld_val) val <= data_i;
      // The three strobes come from mutually exclusive states.
      if (init) begin
        rem  <= val;
        quot <= '0;
        k    <= K_INIT;
      end else if (sub) begin
        rem  <= rem - k;
        quot <= quot + 8'd1;
      end else if (next_k) begin
        rem  <= quot;
        quot <= '0;
        k    <= k + 8'd1;
      end
    end
  end

  assign ge       = (rem >= k);
  assign rem_zero = (rem == '0);
  assign quot_one = (quot == 8'd1);
endmodule

// File: rtl/inv_factorial.sv
// Inverse factorial: given Data_i, finds n with n! == Data_i by repeatedly
// dividing by 2, 3, 4, ... (restoring subtraction). Controller FSM here,
// arithmetic in inv_fact_datapath.
//   clk, rst : clock, async active-high reset
//   start    : begin a search (only honoured in IDLE)
//   Data_i   : candidate factorial, captured with start
//   Out      : n, or 0 if Data_i is not a factorial
//   exact    : 1 when Data_i is an exact factorial
//   done     : one-cycle completion pulse (Out/exact valid with it)
module inv_factorial
  import inv_fact_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] Data_i,
  output logic [DATA_W-1:0] Out,
  output logic              exact,
  output logic              done
);
  state_t state_q, state_d;

  logic              ld_val, init, sub, next_k;
  logic [DATA_W-1:0] val, k;
  logic              ge, rem_zero, quot_one;

  // result write strobe and value, consumed by the Out/exact register
  logic              res_we;
  logic [DATA_W-1:0] res_out;
  logic              res_exact;

  inv_fact_datapath u_dp (
    .clk      (clk),
    .rst      (rst),
    .ld_val   (ld_val),
    .init     (init),
    .sub      (sub),
    .next_k   (next_k),
    .data_i   (Data_i),
    .val      (val),
    .k        (k),
    .ge       (ge),
    .rem_zero (rem_zero),
    .quot_one (quot_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = (val <= 8'd1) ? DONE : DIV;
      DIV:   if (!ge) state_d = CHECK;
      CHECK: state_d = (!rem_zero || quot_one) ? DONE : DIV;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_val    = 1'b0;
    init      = 1'b0;
    sub       = 1'b0;
    next_k    = 1'b0;
    res_we    = 1'b0;
    res_out   = '0;
    res_exact = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:  ld_val = start;
      LOAD: begin
        if (val <= 8'd1) begin
          // 0 has no inverse; 1 is reported as 1! (not 0!)
          res_we    = 1'b1;
          res_out   = val;
          res_exact = (val == 8'd1);
        end else begin
          init = 1'b1;
        end
      end
      DIV:   sub = ge;
      CHECK: begin
        if (!rem_zero) begin
          res_we = 1'b1;
        end else if (quot_one) begin
          res_we    = 1'b1;
          res_out   = k;
          res_exact = 1'b1;
        end else begin
          next_k = 1'b1;
        end
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Result is held until the next search overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Out   <= '0;
      exact <= 1'b0;
    end else if (res_we) begin
      Out   <= res_out;
      exact <= res_exact;
    end
  end
endmodule

// File: tb/tb_inv_factorial.sv
module tb_inv_factorial;
  import inv_fact_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] Data_i = '0;
  logic [7:0] Out;
  logic       exact;
  logic       done;

  inv_factorial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Data_i (Data_i),
    .Out    (Out),
    .exact  (exact),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       exact;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] out;
    logic       exact;
    int         lat;   // edges from accept edge (inclusive) to DONE; 0 = unchecked
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  // Independent reference: search n with n! == d by forward multiplication.
  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    int   f;
    e.out   = 8'd0;
    e.exact = 1'b0;
    f = 1;
    for (int n = 1; n <= 6; n++) begin
      f = f * n;
      if (f == int'(d)) begin
        e.out   = n[7:0];
        e.exact = 1'b1;
        return e;
      end
    end
    return e;
  endfunction

  // Scoreboard check on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_cmp++;
      if (prev_done) begin
        n_err++;
        $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: Out=%0d exact=%0d, required no done", Out, exact);
      end else begin
        e = sb.pop_front();
        if (Out !== e.out || exact !== e.exact) begin
          n_err++;
          $display("FAIL result: Out=%0d exact=%0d, required Out=%0d exact=%0d",
                   Out, exact, e.out, e.exact);
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_done(input string name, input int lat, input int n0);
    int n;
    n = n0;
    while (!done && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no done after %0d edges, required done", name, n);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (lat != 0) begin
      n_cmp++;
      if (n != lat) begin
        n_err++;
        $display("FAIL %s latency: %0d edges, required %0d", name, n, lat);
      end
    end
  endtask

  task automatic search(input logic [7:0] d, input exp_t e, input int lat);
    @(negedge clk);
    start  = 1'b1;
    Data_i = d;
    sb.push_back(e);
    @(posedge clk);           // accept edge
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("search_%0d", d), lat, 1);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    logic [7:0] r;
    int   n;

    vecs[0] = '{8'd0,   8'd0, 1'b0, 2};
    vecs[1] = '{8'd1,   8'd1, 1'b1, 2};
    vecs[2] = '{8'd2,   8'd2, 1'b1, 5};
    vecs[3] = '{8'd24,  8'd4, 1'b1, 25};
    vecs[4] = '{8'd120, 8'd5, 1'b1, 0};
    vecs[5] = '{8'd7,   8'd0, 1'b0, 7};
    vecs[6] = '{8'd12,  8'd0, 1'b0, 16};
    vecs[7] = '{8'd6,   8'd3, 1'b1, 10};

    // reset state
    #12;
    n_cmp++;
    if (Out !== 8'd0 || exact !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: Out=%0d exact=%0d done=%0d, required 0/0/0", Out, exact, done);
    end
    @(negedge clk);
    rst = 1'b0;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      e.out   = vecs[i].out;
      e.exact = vecs[i].exact;
      search(vecs[i].data, e, vecs[i].lat);
    end

    // results hold while idle
    repeat (4) @(negedge clk);
    n_cmp++;
    if (Out !== 8'd3 || exact !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hold: Out=%0d exact=%0d, required 3/1", Out, exact);
    end

    // random values against the model
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom_range(0, 255));
      search(r, model(r), 0);
    end

    // reset mid-search: 120, reset 10 edges into DIV, no done
    search(8'd6, model(8'd6), 0);
    @(negedge clk);
    start = 1'b1; Data_i = 8'd120;   // nothing pushed: this search must abort
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dut.state_q != DIV && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut.state_q != IDLE || Out !== 8'd0 || exact !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: state=%0d Out=%0d exact=%0d done=%0d, required IDLE/0/0/0",
               dut.state_q, Out, exact, done);
    end
    @(negedge clk);
    rst = 1'b0;
    search(8'd6, model(8'd6), 10);

    // start ignored while busy, then held start gives back-to-back search
    @(negedge clk);
    start = 1'b1; Data_i = 8'd120;
    e.out = 8'd5; e.exact = 1'b1; sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; Data_i = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; Data_i = 8'd6;
    e.out = 8'd3; e.exact = 1'b1; sb.push_back(e);
    wait_done("busy_120", 0, 0);
    @(posedge clk);           // DONE -> IDLE
    @(posedge clk);           // IDLE accepts held start
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (dut.state_q != LOAD) begin
      n_err++;
      $display("FAIL back_to_back_accept: state=%0d, required LOAD", dut.state_q);
    end
    wait_done("held_6", 0, 1);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
